// File: rtl/i3c_bus_arbiter.sv
// rtl/i3c_bus_arbiter.sv - I3C bus-ownership arbiter: IBI-over-mastership round-robin grant with beat-gated tenure
module i3c_bus_arbiter #(
    parameter int NUM_DEV   = 8,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_DEV-1:0]             ibi_req,
    input  logic [NUM_DEV-1:0]             mst_req,
    input  logic                           beat_valid,
    input  logic                           beat_last,
    output logic                           beat_ready,
    output logic [NUM_DEV-1:0]             grant,
    output logic [$clog2(NUM_DEV)-1:0]     grant_id,
    output logic                           grant_ibi,
    output logic [1:0]                     state,
    output logic [$clog2(MAX_BURST+1)-1:0] beat_count,
    output logic                           xfer_done,
    output logic [1:0]                     xfer_status
);
    localparam int ID_W  = $clog2(NUM_DEV);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MST  = 2'b01,
        ST_DATA = 2'b10
    } i3c_state_t;

    i3c_state_t       state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             grant_ibi_q, grant_ibi_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             done_q, done_d;
    logic [1:0]       status_q, status_d;

    logic [NUM_DEV-1:0] arb_req;
    logic               arb_ibi;
    logic               arb_found;
    logic [ID_W-1:0]    arb_win;
    logic               still_req;
    logic [CNT_W-1:0]   cnt_inc;
    logic [TMO_W-1:0]   tmo_inc;

    // Round-robin search starts just after the last device that completed a tenure.
    always_comb begin
        int idx;
        idx       = 0;
        arb_ibi   = |ibi_req;
        arb_req   = arb_ibi ? ibi_req : mst_req;
        arb_found = 1'b0;
        arb_win   = '0;
        for (int i = 1; i <= NUM_DEV; i++) begin
            idx = (int'(ptr_q) + i) % NUM_DEV;
            if (!arb_found && arb_req[idx]) begin
                arb_found = 1'b1;
                arb_win   = ID_W'(idx);
            end
        end
    end

    assign still_req = grant_ibi_q ? ibi_req[grant_id_q] : mst_req[grant_id_q];
    assign cnt_inc   = cnt_q + 1'b1;
    assign tmo_inc   = tmo_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        grant_ibi_d = grant_ibi_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        done_d      = 1'b0;
        status_d    = status_q;
        case (state_q)
            ST_IDLE: begin
                if (!done_q && arb_found) begin
                    state_d     = ST_MST;
                    grant_id_d  = arb_win;
                    grant_ibi_d = arb_ibi;
                    cnt_d       = '0;
                    tmo_d       = '0;
                end
            end
            ST_MST: begin
                tmo_d = '0;
                if (still_req) begin
                    state_d = ST_DATA;
                end else begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    status_d = 2'b11;
                end
            end
            ST_DATA: begin
                if (beat_valid) begin
                    cnt_d = cnt_inc;
                    tmo_d = '0;
                    if (beat_last) begin
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        status_d = 2'b00;
                        ptr_d    = grant_id_q;
                    end else if (cnt_inc == CNT_W'(MAX_BURST)) begin
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        status_d = 2'b01;
                        ptr_d    = grant_id_q;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_W'(TIMEOUT)) begin
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        status_d = 2'b10;
                        ptr_d    = grant_id_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_id_q  <= '0;
            grant_ibi_q <= 1'b0;
            ptr_q       <= ID_W'(NUM_DEV - 1);
            cnt_q       <= '0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            status_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            grant_ibi_q <= grant_ibi_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            done_q      <= done_d;
            status_q    <= status_d;
        end
    end

    assign grant       = (state_q != ST_IDLE) ? ({{(NUM_DEV-1){1'b0}}, 1'b1} << grant_id_q) : '0;
    assign grant_id    = grant_id_q;
    assign grant_ibi   = grant_ibi_q;
    assign beat_ready  = (state_q == ST_DATA);
    assign state       = state_q;
    assign beat_count  = cnt_q;
    assign xfer_done   = done_q;
    assign xfer_status = status_q;
endmodule

// File: tb/tb_i3c_bus_arbiter.sv
// tb/tb_i3c_bus_arbiter.sv - self-checking bench for i3c_bus_arbiter: vector table with scoreboard plus corner sequences
module tb_i3c_bus_arbiter;
    localparam int NUM_DEV   = 8;
    localparam int MAX_BURST = 16;
    localparam int TIMEOUT   = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ibi_req, mst_req;
    logic       beat_valid, beat_last;
    logic       beat_ready;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_ibi;
    logic [1:0] state;
    logic [4:0] beat_count;
    logic       xfer_done;
    logic [1:0] xfer_status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i3c_bus_arbiter #(.NUM_DEV(NUM_DEV), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ibi_req(ibi_req), .mst_req(mst_req),
        .beat_valid(beat_valid), .beat_last(beat_last), .beat_ready(beat_ready),
        .grant(grant), .grant_id(grant_id), .grant_ibi(grant_ibi), .state(state),
        .beat_count(beat_count), .xfer_done(xfer_done), .xfer_status(xfer_status)
    );

    typedef struct {
        logic       rst;
        logic [7:0] ibi, mst;
        logic       bv, bl;
        logic [1:0] st;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       gibi, rdy, done;
        logic [1:0] xs;
        logic [4:0] cnt;
        logic       chk_id, chk_xs;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic r, logic [7:0] ibi, logic [7:0] mst, logic bv, logic bl,
                                logic [1:0] st, logic [7:0] gnt, logic [2:0] id, logic gibi,
                                logic rdy, logic done, logic [1:0] xs, logic [4:0] cnt,
                                logic chk_id, logic chk_xs);
        vec_t v;
        v.rst = r; v.ibi = ibi; v.mst = mst; v.bv = bv; v.bl = bl;
        v.st = st; v.gnt = gnt; v.id = id; v.gibi = gibi; v.rdy = rdy;
        v.done = done; v.xs = xs; v.cnt = cnt; v.chk_id = chk_id; v.chk_xs = chk_xs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] ibi, input logic [7:0] mst, input logic bv, input logic bl);
        ibi_req = ibi; mst_req = mst; beat_valid = bv; beat_last = bl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t e;
        int   rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        tick();

        // rst ibi   mst   bv bl  st  gnt   id gibi rdy done xs cnt chk_id chk_xs
        tbl.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 8'h04, 0, 0, 1, 8'h04, 2, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 8'h04, 0, 0, 2, 8'h04, 2, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 8'h04, 1, 0, 2, 8'h04, 2, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 2, 8'h04, 2, 0, 1, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 1, 0, 3, 0, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 8'h80, 8'h01, 0, 0, 1, 8'h80, 7, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h80, 8'h01, 0, 0, 2, 8'h80, 7, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 8'h01, 1, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 8'h01, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h01, 0, 0, 1, 8'h01, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 8'h01, 0, 0, 2, 8'h01, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 1));

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            set_in(tbl[i].ibi, tbl[i].mst, tbl[i].bv, tbl[i].bl);
            sb.push_back(tbl[i]);
            tick();
            e = sb.pop_front();
            chk($sformatf("v%0d state", i), 32'(state), 32'(e.st));
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(e.gnt));
            chk($sformatf("v%0d beat_ready", i), 32'(beat_ready), 32'(e.rdy));
            chk($sformatf("v%0d xfer_done", i), 32'(xfer_done), 32'(e.done));
            chk($sformatf("v%0d beat_count", i), 32'(beat_count), 32'(e.cnt));
            if (e.chk_id) begin
                chk($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(e.id));
                chk($sformatf("v%0d grant_ibi", i), 32'(grant_ibi), 32'(e.gibi));
            end
            if (e.chk_xs) chk($sformatf("v%0d xfer_status", i), 32'(xfer_status), 32'(e.xs));
        end

        // round-robin over four mastership requesters with a bus gap after each done
        do_reset();
        set_in(8'h00, 8'h0F, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr%0d mst state", k), 32'(state), 32'd1);
            chk($sformatf("rr%0d grant_id", k), 32'(grant_id), 32'(rr_exp[k]));
            tick();
            chk($sformatf("rr%0d data state", k), 32'(state), 32'd2);
            beat_valid = 1'b1; beat_last = 1'b1;
            tick();
            chk($sformatf("rr%0d done", k), 32'(xfer_done), 32'd1);
            chk($sformatf("rr%0d status", k), 32'(xfer_status), 32'd0);
            beat_valid = 1'b0; beat_last = 1'b0;
            tick();
            chk($sformatf("rr%0d gap state", k), 32'(state), 32'd0);
        end

        // burst limit, then the same with last on the final beat
        do_reset();
        set_in(8'h00, 8'h01, 1'b0, 1'b0);
        tick(); tick();
        set_in(8'h00, 8'h00, 1'b1, 1'b0);
        repeat (MAX_BURST - 1) tick();
        chk("burst pre count", 32'(beat_count), 32'(MAX_BURST - 1));
        chk("burst pre done", 32'(xfer_done), 32'd0);
        tick();
        chk("burst done", 32'(xfer_done), 32'd1);
        chk("burst status", 32'(xfer_status), 32'd1);
        chk("burst count", 32'(beat_count), 32'(MAX_BURST));
        chk("burst state", 32'(state), 32'd0);
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        mst_req = 8'h01;
        tick();
        chk("burst2 grant_id", 32'(grant_id), 32'd0);
        tick();
        set_in(8'h00, 8'h00, 1'b1, 1'b0);
        repeat (MAX_BURST - 1) tick();
        beat_last = 1'b1;
        tick();
        chk("burst2 done", 32'(xfer_done), 32'd1);
        chk("burst2 status", 32'(xfer_status), 32'd0);
        chk("burst2 count", 32'(beat_count), 32'(MAX_BURST));
        set_in(8'h00, 8'h00, 1'b0, 1'b0);

        // timeout, then a beat on the deadline cycle restarts the count
        do_reset();
        mst_req = 8'h01;
        tick(); tick();
        mst_req = 8'h00;
        repeat (TIMEOUT - 1) tick();
        chk("tmo pre state", 32'(state), 32'd2);
        chk("tmo pre done", 32'(xfer_done), 32'd0);
        tick();
        chk("tmo done", 32'(xfer_done), 32'd1);
        chk("tmo status", 32'(xfer_status), 32'd2);
        chk("tmo state", 32'(state), 32'd0);
        tick();
        mst_req = 8'h01;
        tick(); tick();
        mst_req = 8'h00;
        repeat (TIMEOUT - 1) tick();
        beat_valid = 1'b1;
        tick();
        beat_valid = 1'b0;
        chk("tmo2 deadline state", 32'(state), 32'd2);
        chk("tmo2 deadline done", 32'(xfer_done), 32'd0);
        chk("tmo2 count", 32'(beat_count), 32'd1);
        repeat (TIMEOUT - 1) tick();
        chk("tmo2 pre done", 32'(xfer_done), 32'd0);
        tick();
        chk("tmo2 done", 32'(xfer_done), 32'd1);
        chk("tmo2 status", 32'(xfer_status), 32'd2);

        // abort leaves the pointer alone so the aborted device wins again
        do_reset();
        mst_req = 8'h02;
        tick(); tick();
        set_in(8'h00, 8'h00, 1'b1, 1'b1);
        tick();
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        mst_req = 8'h08;
        tick();
        chk("abort grant_id", 32'(grant_id), 32'd3);
        mst_req = 8'h00;
        tick();
        chk("abort done", 32'(xfer_done), 32'd1);
        chk("abort status", 32'(xfer_status), 32'd3);
        chk("abort state", 32'(state), 32'd0);
        mst_req = 8'h18;
        tick();
        chk("abort gap state", 32'(state), 32'd0);
        tick();
        chk("regrant state", 32'(state), 32'd1);
        chk("regrant grant_id", 32'(grant_id), 32'd3);

        // reset in the middle of a data tenure
        tick();
        beat_valid = 1'b1;
        tick();
        rst = 1'b1; beat_last = 1'b1;
        tick();
        chk("rst state", 32'(state), 32'd0);
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst grant_id", 32'(grant_id), 32'd0);
        chk("rst grant_ibi", 32'(grant_ibi), 32'd0);
        chk("rst beat_ready", 32'(beat_ready), 32'd0);
        chk("rst beat_count", 32'(beat_count), 32'd0);
        chk("rst xfer_done", 32'(xfer_done), 32'd0);
        chk("rst xfer_status", 32'(xfer_status), 32'd0);
        rst = 1'b0;
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
